// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
// mem_wb_stage
//   MEM->WB pipeline stage. The writeback value is formed from the incoming
//   MEM-stage entry and then stored. This covers load-field extraction with
//   sign/zero extension, or the ALU result. The head entry is presented to
//   the register file through a valid/ready handshake. An optional skid
//   register lets MEM keep issuing for one cycle while WB stalls.
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flush           synchronous flush: clears every held entry at the next edge
//   in_valid/ready  MEM-side handshake
//   mem_rdata       XLEN-aligned read word; addr_lo selects the byte offset
//   alu_result      ALU result, written back when mem_to_reg_in=0
//   load_size       0=byte 1=half 2=word 3=double; load_unsigned picks zero-extend
//   reg_write_in    entry writes rd_in (suppressed for rd_in==0)
//   out_valid/ready WB-side handshake
//   wb_data/rd/en   head entry toward the register file
//   fwd_*           forwarding tap to EX, identical to wb_data/wb_rd/wb_en
//   occupancy       number of entries held (0..2)
module mem_wb_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int SKID   = 1,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_en,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [1:0]        occupancy
);

  // ---------------- writeback value, computed before capture ----------------
  logic [XLEN-1:0] shifted;
  logic [63:0]     sh64;
  logic [63:0]     ext64;
  logic [1:0]      eff_size;
  logic [XLEN-1:0] wb_value;
  logic            in_we;

  // Extension is done in a 64-bit domain so one description serves both
  // XLEN=32 and XLEN=64; the result is truncated back to XLEN. Bytes shifted
  // in from above the read word are zero.
  always_comb begin
    shifted  = mem_rdata >> {addr_lo, 3'b000};
    sh64     = 64'(shifted);
    eff_size = (XLEN == 32 && load_size == 2'd3) ? 2'd2 : load_size;
    case (eff_size)
      2'd0:    ext64 = load_unsigned ? {56'd0, sh64[7:0]}  : {{56{sh64[7]}},  sh64[7:0]};
      2'd1:    ext64 = load_unsigned ? {48'd0, sh64[15:0]} : {{48{sh64[15]}}, sh64[15:0]};
      2'd2:    ext64 = load_unsigned ? {32'd0, sh64[31:0]} : {{32{sh64[31]}}, sh64[31:0]};
      default: ext64 = sh64;
    endcase
    wb_value = mem_to_reg_in ? XLEN'(ext64) : alu_result;
  end

  // A write to x0 is dropped at capture so wb_en can never fire for rd 0.
  assign in_we = reg_write_in & (rd_in != '0);

  // ---------------- head register (drives every output) ----------------
  logic              head_valid_reg;
  logic [XLEN-1:0]   head_data_reg;
  logic [REG_AW-1:0] head_rd_reg;
  logic              head_we_reg;
  logic              accept;
  logic              deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = head_valid_reg & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_reg;
      logic [XLEN-1:0]   skid_data_reg;
      logic [REG_AW-1:0] skid_rd_reg;
      logic              skid_we_reg;

      // Ready depends only on a flop, so the MEM side sees no combinational
      // path from out_ready.
      assign in_ready  = ~skid_valid_reg;
      assign occupancy = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

      // The skid slot is only ever full while the head is full, and in_ready
      // is low whenever it is full, so a delivery that refills from skid
      // never coincides with an accept.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          head_valid_reg <= 1'b0;
          head_data_reg  <= '0;
          head_rd_reg    <= '0;
          head_we_reg    <= 1'b0;
          skid_valid_reg <= 1'b0;
          skid_data_reg  <= '0;
          skid_rd_reg    <= '0;
          skid_we_reg    <= 1'b0;
        end else if (flush) begin
          head_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
        end else if (deliver) begin
          if (skid_valid_reg) begin
            head_data_reg  <= skid_data_reg;
            head_rd_reg    <= skid_rd_reg;
            head_we_reg    <= skid_we_reg;
            skid_valid_reg <= 1'b0;
          end else if (accept) begin
            head_data_reg  <= wb_value;
            head_rd_reg    <= rd_in;
            head_we_reg    <= in_we;
          end else begin
            head_valid_reg <= 1'b0;
          end
        end else if (accept) begin
          if (head_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= wb_value;
            skid_rd_reg    <= rd_in;
            skid_we_reg    <= in_we;
          end else begin
            head_valid_reg <= 1'b1;
            head_data_reg  <= wb_value;
            head_rd_reg    <= rd_in;
            head_we_reg    <= in_we;
          end
        end
      end
    end else begin : g_single
      assign in_ready  = ~head_valid_reg | out_ready;
      assign occupancy = {1'b0, head_valid_reg};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          head_valid_reg <= 1'b0;
          head_data_reg  <= '0;
          head_rd_reg    <= '0;
          head_we_reg    <= 1'b0;
        end else if (flush) begin
          head_valid_reg <= 1'b0;
        end else if (accept) begin
          head_valid_reg <= 1'b1;
          head_data_reg  <= wb_value;
          head_rd_reg    <= rd_in;
          head_we_reg    <= in_we;
        end else if (deliver) begin
          head_valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = head_valid_reg;
  assign wb_data   = head_data_reg;
  assign wb_rd     = head_rd_reg;
  assign wb_en     = head_valid_reg & head_we_reg;
  assign fwd_valid = wb_en;
  assign fwd_rd    = head_rd_reg;
  assign fwd_data  = head_data_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
// Bench for mem_wb_stage: instance A (XLEN=64, SKID=1) and instance B
// (XLEN=32, SKID=0). Accepted entries are pushed into per-instance
// scoreboards. The expected value comes from a byte-gathering reference
// model. Monitors pop and compare on every delivery.
module tb_mem_wb_stage;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        en;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  // instance A signals
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_wb_en, a_fwd_valid;
  logic [63:0] a_mem_rdata, a_alu_result, a_wb_data, a_fwd_data;
  logic [2:0]  a_addr_lo;
  logic [1:0]  a_load_size, a_occupancy;
  logic        a_load_unsigned, a_mem_to_reg, a_reg_write;
  logic [4:0]  a_rd, a_wb_rd, a_fwd_rd;

  // instance B signals
  logic        b_flush;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_wb_en, b_fwd_valid;
  logic [31:0] b_mem_rdata, b_alu_result, b_wb_data, b_fwd_data;
  logic [1:0]  b_addr_lo;
  logic [1:0]  b_load_size, b_occupancy;
  logic        b_load_unsigned, b_mem_to_reg, b_reg_write;
  logic [4:0]  b_rd, b_wb_rd, b_fwd_rd;

  mem_wb_stage #(.XLEN(64), .REG_AW(5), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mem_rdata(a_mem_rdata), .alu_result(a_alu_result), .addr_lo(a_addr_lo),
    .load_size(a_load_size), .load_unsigned(a_load_unsigned),
    .mem_to_reg_in(a_mem_to_reg), .reg_write_in(a_reg_write), .rd_in(a_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .wb_data(a_wb_data), .wb_rd(a_wb_rd), .wb_en(a_wb_en),
    .fwd_valid(a_fwd_valid), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data),
    .occupancy(a_occupancy)
  );

  mem_wb_stage #(.XLEN(32), .REG_AW(5), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mem_rdata(b_mem_rdata), .alu_result(b_alu_result), .addr_lo(b_addr_lo),
    .load_size(b_load_size), .load_unsigned(b_load_unsigned),
    .mem_to_reg_in(b_mem_to_reg), .reg_write_in(b_reg_write), .rd_in(b_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .wb_data(b_wb_data), .wb_rd(b_wb_rd), .wb_en(b_wb_en),
    .fwd_valid(b_fwd_valid), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data),
    .occupancy(b_occupancy)
  );

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   b_deliveries = 0;
  bit   last_acc_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, expv);
  endtask

  // Reference: gather the requested bytes one at a time starting at the
  // offset, zero past the top of the word, then extend by inspecting the
  // field's top bit.
  function automatic exp_t model(input int xlen, input logic [63:0] rdata, input logic [63:0] alu,
                                 input int addr, input int size, input bit uns, input bit m2r,
                                 input bit rw, input logic [4:0] rd);
    exp_t        e;
    int          nb;
    logic [63:0] v;
    logic [63:0] wmask;
    nb = (xlen == 32 && size == 3) ? 4 : (1 << size);
    v = 64'd0;
    for (int b = 0; b < nb; b++)
      if (addr + b < xlen / 8) v = v | (64'(rdata[8*(addr+b) +: 8]) << (8*b));
    if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    wmask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e.data = (m2r ? v : alu) & wmask;
    e.rd = rd;
    e.en = rw && (rd != 5'd0);
    return e;
  endfunction

  // One clock: sample the handshake on the falling edge, record the
  // accepted entry at the rising edge, return just after it.
  task automatic step;
    bit   acc_a, acc_b;
    exp_t ea, eb;
    @(negedge clk);
    acc_a = a_in_valid && a_in_ready && !flush;
    acc_b = b_in_valid && b_in_ready && !b_flush;
    ea = model(64, a_mem_rdata, a_alu_result, int'(a_addr_lo), int'(a_load_size), a_load_unsigned,
               a_mem_to_reg, a_reg_write, a_rd);
    eb = model(32, 64'(b_mem_rdata), 64'(b_alu_result), int'(b_addr_lo), int'(b_load_size),
               b_load_unsigned, b_mem_to_reg, b_reg_write, b_rd);
    @(posedge clk);
    if (acc_a) sb_a.push_back(ea);
    if (acc_b) sb_b.push_back(eb);
    last_acc_a = acc_a;
    #1;
  endtask

  task automatic rand_a;
    a_mem_rdata = {$urandom, $urandom};
    a_alu_result = {$urandom, $urandom};
    a_addr_lo = 3'($urandom);
    a_load_size = 2'($urandom);
    a_load_unsigned = 1'($urandom);
    a_mem_to_reg = 1'($urandom);
    a_reg_write = 1'($urandom);
    a_rd = 5'($urandom);
  endtask

  task automatic rand_b;
    b_mem_rdata = $urandom;
    b_alu_result = $urandom;
    b_addr_lo = 2'($urandom);
    b_load_size = 2'($urandom);
    b_load_unsigned = 1'($urandom);
    b_mem_to_reg = 1'($urandom);
    b_reg_write = 1'($urandom);
    b_rd = 5'($urandom);
  endtask

  // Monitor A: state checks against the scoreboard depth, then compare
  // the delivered head against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("a_occupancy", 64'(a_occupancy), 64'(sb_a.size()));
      check("a_in_ready", 64'(a_in_ready), 64'(sb_a.size() < 2));
      check("a_out_valid", 64'(a_out_valid), 64'(sb_a.size() != 0));
      if (a_out_valid && a_out_ready) begin
        if (sb_a.size() == 0) begin
          check("a_unexpected_deliver", 64'd1, 64'd0);
        end else begin
          e = sb_a.pop_front();
          check("a_wb_data", a_wb_data, e.data);
          check("a_wb_rd", 64'(a_wb_rd), 64'(e.rd));
          check("a_wb_en", 64'(a_wb_en), 64'(e.en));
          check("a_fwd_valid", 64'(a_fwd_valid), 64'(e.en));
          check("a_fwd_rd", 64'(a_fwd_rd), 64'(e.rd));
          check("a_fwd_data", a_fwd_data, e.data);
          $display("A deliver rd=%0d en=%0d data=%h", a_wb_rd, a_wb_en, a_wb_data);
        end
      end
      if (flush) sb_a.delete();
    end
  end

  // Monitor B: single-entry stage, ready must follow out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("b_occupancy", 64'(b_occupancy), 64'(sb_b.size()));
      check("b_in_ready", 64'(b_in_ready), 64'(sb_b.size() == 0 || b_out_ready));
      check("b_out_valid", 64'(b_out_valid), 64'(sb_b.size() != 0));
      if (b_out_valid && b_out_ready) begin
        b_deliveries++;
        if (sb_b.size() == 0) begin
          check("b_unexpected_deliver", 64'd1, 64'd0);
        end else begin
          e = sb_b.pop_front();
          check("b_wb_data", 64'(b_wb_data), e.data);
          check("b_wb_rd", 64'(b_wb_rd), 64'(e.rd));
          check("b_wb_en", 64'(b_wb_en), 64'(e.en));
          check("b_fwd_data", 64'(b_fwd_data), e.data);
          $display("B deliver rd=%0d en=%0d data=%h", b_wb_rd, b_wb_en, b_wb_data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; flush = 1'b0; b_flush = 1'b0;
    a_in_valid = 0; a_out_ready = 0; rand_a();
    b_in_valid = 0; b_out_ready = 0; rand_b();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_wb_en", 64'(a_wb_en), 64'd0);
    check("rst_fwd_valid", 64'(a_fwd_valid), 64'd0);
    check("rst_wb_data", a_wb_data, 64'd0);
    check("rst_wb_rd", 64'(a_wb_rd), 64'd0);
    check("rst_occupancy", 64'(a_occupancy), 64'd0);
    check("rst_in_ready_a", 64'(a_in_ready), 64'd1);
    check("rst_in_ready_b", 64'(b_in_ready), 64'd1);
    reset = 1'b0;

    // load byte, signed then unsigned
    a_in_valid = 1; a_out_ready = 1;
    a_mem_rdata = 64'h0000_0000_0000_8000; a_alu_result = 64'hDEAD_BEEF;
    a_addr_lo = 3'd1; a_load_size = 2'd0; a_load_unsigned = 0;
    a_mem_to_reg = 1; a_reg_write = 1; a_rd = 5'd5;
    step();
    check("lb_signed_data", a_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_signed_rd", 64'(a_wb_rd), 64'd5);
    check("lb_signed_en", 64'(a_wb_en), 64'd1);
    a_load_unsigned = 1;
    step();
    check("lbu_data", a_wb_data, 64'h80);

    // ALU result targeting x0
    a_alu_result = 64'h1234; a_mem_to_reg = 0; a_reg_write = 1; a_rd = 5'd0;
    step();
    check("x0_out_valid", 64'(a_out_valid), 64'd1);
    check("x0_wb_en", 64'(a_wb_en), 64'd0);
    check("x0_fwd_valid", 64'(a_fwd_valid), 64'd0);
    check("x0_wb_data", a_wb_data, 64'h1234);
    a_in_valid = 0;
    step();

    // backpressure: A and B fill the stage, C waits at MEM
    a_out_ready = 0; a_in_valid = 1;
    rand_a(); a_rd = 5'd1; a_reg_write = 1;
    step();
    rand_a(); a_rd = 5'd2; a_reg_write = 1;
    step();
    check("bp_occupancy", 64'(a_occupancy), 64'd2);
    check("bp_in_ready", 64'(a_in_ready), 64'd0);
    rand_a(); a_rd = 5'd3; a_reg_write = 1;
    step(); step();
    check("bp_c_held", 64'(a_occupancy), 64'd2);
    a_out_ready = 1;
    last_acc_a = 0;
    for (int i = 0; i < 10 && !last_acc_a; i++) step();
    check("bp_c_accepted", 64'(last_acc_a), 64'd1);
    a_in_valid = 0;
    repeat (4) step();
    check("bp_drained", 64'(sb_a.size()), 64'd0);

    // flush with a full stage and an entry on the input
    a_out_ready = 0; a_in_valid = 1;
    rand_a(); step();
    rand_a(); step();
    rand_a(); flush = 1;
    step();
    flush = 0; a_in_valid = 0;
    check("flush_out_valid", 64'(a_out_valid), 64'd0);
    check("flush_occupancy", 64'(a_occupancy), 64'd0);
    a_out_ready = 1;
    repeat (2) step();

    // asynchronous reset between edges while one entry is held
    a_out_ready = 0; a_in_valid = 1; rand_a(); a_rd = 5'd7; a_reg_write = 1;
    step();
    a_in_valid = 0;
    check("ar_occupancy_before", 64'(a_occupancy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 64'(a_out_valid), 64'd0);
    check("ar_wb_en", 64'(a_wb_en), 64'd0);
    check("ar_occupancy", 64'(a_occupancy), 64'd0);
    check("ar_wb_data", a_wb_data, 64'd0);
    sb_a.delete(); sb_b.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // randomized traffic with occasional flushes on A
    for (int i = 0; i < 400; i++) begin
      rand_a();
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 0; a_in_valid = 0; a_out_ready = 1;
    repeat (4) step();
    check("a_final_drain", 64'(sb_a.size()), 64'd0);

    // B: continuous stream with out_ready held high, one entry per cycle
    b_in_valid = 1; b_out_ready = 1;
    d0 = b_deliveries;
    for (int i = 0; i < 60; i++) begin
      rand_b();
      step();
      check("b_occupancy_max", 64'(b_occupancy <= 2'd1), 64'd1);
    end
    check("b_stream_rate", 64'(b_deliveries - d0), 64'd59);
    for (int i = 0; i < 80; i++) begin
      rand_b();
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    b_in_valid = 0; b_out_ready = 1;
    repeat (3) step();
    check("b_final_drain", 64'(sb_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
